// File: rtl/led_page_scanner.sv
// Debug LED pager: drives one LED_W-wide slice of the data words, or the sticky
// flag page, to the board LEDs, chosen by a switch or by a timed auto scan.
module led_page_scanner #(
    parameter int NUM_WORDS = 2,
    parameter int WORD_W    = 32,
    parameter int LED_W     = 8,
    parameter int FLAG_W    = 2,
    parameter int SCAN_DIV  = 50000000,
    localparam int BPW       = WORD_W / LED_W,
    localparam int NUM_PAGES = NUM_WORDS * BPW + 1,
    localparam int PAGE_W    = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_WORDS*WORD_W-1:0] din,
    input  logic [FLAG_W-1:0]           flags,
    input  logic [PAGE_W-1:0]           sel,
    input  logic                        auto_mode,
    input  logic                        freeze,
    input  logic                        sticky_clr,
    output logic [LED_W-1:0]            led,
    output logic [PAGE_W-1:0]           page,
    output logic                        page_tick
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(NUM_PAGES - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(SCAN_DIV - 1);

    logic [FLAG_W-1:0] sticky;
    logic [FLAG_W-1:0] sticky_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [PAGE_W-1:0] page_nxt;
    logic [PAGE_W-1:0] sel_page;
    logic [LED_W-1:0]  led_nxt;
    logic              tick_nxt;

    // Next page, dwell count and LED value; the LED is always derived from the
    // page being loaded so the two registers can never disagree.
    always_comb begin
        sticky_nxt = (sticky & ~{FLAG_W{sticky_clr}}) | flags;
        sel_page   = (sel > LAST_PAGE) ? LAST_PAGE : sel;
        page_nxt   = page;
        cnt_nxt    = cnt;
        tick_nxt   = 1'b0;
        led_nxt    = led;

        if (!freeze) begin
            if (auto_mode) begin
                if (cnt == LAST_CNT) begin
                    cnt_nxt  = '0;
                    tick_nxt = 1'b1;
                    page_nxt = (page == LAST_PAGE) ? '0 : page + PAGE_W'(1);
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end else begin
                page_nxt = sel_page;
                cnt_nxt  = '0;
            end

            // Data pages are contiguous LED_W slices of din since WORD_W is a multiple of LED_W.
            led_nxt = LED_W'(sticky);
            for (int p = 0; p < NUM_PAGES - 1; p++) begin
                if (page_nxt == PAGE_W'(p)) begin
                    led_nxt = din[p*LED_W +: LED_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led       <= '0;
            page      <= '0;
            page_tick <= 1'b0;
            cnt       <= '0;
            sticky    <= '0;
        end else begin
            led       <= led_nxt;
            page      <= page_nxt;
            page_tick <= tick_nxt;
            cnt       <= cnt_nxt;
            sticky    <= sticky_nxt;
        end
    end

endmodule

// File: tb/tb_led_page_scanner.sv
// Self-checking bench for led_page_scanner: directed scenarios with literal
// expectations plus a random phase checked every cycle against a page-level model.
module tb_led_page_scanner;

    localparam int NUM_WORDS = 2;
    localparam int WORD_W    = 32;
    localparam int LED_W     = 8;
    localparam int FLAG_W    = 2;
    localparam int SCAN_DIV  = 4;
    localparam int BPW       = WORD_W / LED_W;
    localparam int NP        = NUM_WORDS * BPW + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] din;
    logic [1:0]  flags;
    logic [3:0]  sel;
    logic        auto_mode;
    logic        freeze;
    logic        sticky_clr;
    logic [7:0]  led;
    logic [3:0]  page;
    logic        page_tick;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] DIN_A = {32'hA1B2C3D4, 32'h11223344};

    led_page_scanner #(
        .NUM_WORDS(NUM_WORDS), .WORD_W(WORD_W), .LED_W(LED_W),
        .FLAG_W(FLAG_W), .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .flags(flags), .sel(sel),
        .auto_mode(auto_mode), .freeze(freeze), .sticky_clr(sticky_clr),
        .led(led), .page(page), .page_tick(page_tick)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Page content straight from the page map: word p/BPW, byte p%BPW, last page = flags.
    function automatic logic [7:0] pageValue(input int p, input logic [63:0] d, input logic [1:0] s);
        if (p == NP - 1) return {6'b0, s};
        return d[(p / BPW) * WORD_W + (p % BPW) * LED_W +: LED_W];
    endfunction

    int          m_page;
    int          m_cnt;
    logic [7:0]  m_led;
    logic        m_tick;
    logic [1:0]  m_sticky;
    bit          model_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_page = 0; m_cnt = 0; m_led = 8'h00; m_tick = 1'b0; m_sticky = 2'b00;
            model_valid = 1'b1;
        end else if (model_valid) begin
            m_tick = 1'b0;
            if (!freeze) begin
                if (auto_mode) begin
                    if (m_cnt == SCAN_DIV - 1) begin
                        m_cnt  = 0;
                        m_page = (m_page + 1) % NP;
                        m_tick = 1'b1;
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end else begin
                    m_page = (int'(sel) >= NP) ? NP - 1 : int'(sel);
                    m_cnt  = 0;
                end
                m_led = pageValue(m_page, din, m_sticky);
            end
            m_sticky = (sticky_clr ? 2'b00 : m_sticky) | flags;
        end
        #1;
        if (model_valid) begin
            checkOutput("model_led", 32'(led), 32'(m_led));
            checkOutput("model_page", 32'(page), 32'(m_page));
            checkOutput("model_tick", 32'(page_tick), 32'(m_tick));
        end
    end

    task automatic applyStimulus(input logic r, input logic [63:0] d, input logic [1:0] f,
                                 input logic [3:0] s, input logic a, input logic fr, input logic c);
        rst = r; din = d; flags = f; sel = s; auto_mode = a; freeze = fr; sticky_clr = c;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [7:0] expMap [8] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
    int         tickCount;
    logic [3:0] p0;
    logic [7:0] l0;
    logic       curAuto;

    initial begin
        // Reset for two cycles with random inputs
        applyStimulus(1'b1, {$urandom, $urandom}, 2'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        waitCycles(1);
        applyStimulus(1'b1, {$urandom, $urandom}, 2'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        waitCycles(1);
        checkOutput("reset_led", 32'(led), 32'h0);
        checkOutput("reset_page", 32'(page), 32'h0);
        checkOutput("reset_tick", 32'(page_tick), 32'h0);
        applyStimulus(1'b0, 64'h0, 2'b00, 4'd8, 1'b0, 1'b0, 1'b0);
        waitCycles(1);
        checkOutput("reset_sticky", 32'(led), 32'h0);

        // Manual page map
        for (int s = 0; s < 8; s++) begin
            applyStimulus(1'b0, DIN_A, 2'b00, 4'(s), 1'b0, 1'b0, 1'b0);
            waitCycles(1);
            checkOutput("manual_led", 32'(led), 32'(expMap[s]));
            checkOutput("manual_page", 32'(page), 32'(s));
        end
        applyStimulus(1'b0, DIN_A, 2'b00, 4'd9, 1'b0, 1'b0, 1'b0);
        waitCycles(1);
        checkOutput("sel_out_of_range_page", 32'(page), 32'd8);
        checkOutput("sel_out_of_range_led", 32'(led), 32'h0);

        // Sticky flags
        applyStimulus(1'b0, DIN_A, 2'b10, 4'd8, 1'b0, 1'b0, 1'b0);
        waitCycles(1);
        applyStimulus(1'b0, DIN_A, 2'b00, 4'd8, 1'b0, 1'b0, 1'b0);
        waitCycles(1);
        checkOutput("sticky_set", 32'(led), 32'h02);
        waitCycles(5);
        checkOutput("sticky_hold", 32'(led), 32'h02);
        applyStimulus(1'b0, DIN_A, 2'b00, 4'd8, 1'b0, 1'b0, 1'b1);
        waitCycles(1);
        applyStimulus(1'b0, DIN_A, 2'b00, 4'd8, 1'b0, 1'b0, 1'b0);
        waitCycles(1);
        checkOutput("sticky_clear", 32'(led), 32'h00);
        applyStimulus(1'b0, DIN_A, 2'b01, 4'd8, 1'b0, 1'b0, 1'b1);
        waitCycles(1);
        applyStimulus(1'b0, DIN_A, 2'b00, 4'd8, 1'b0, 1'b0, 1'b0);
        waitCycles(1);
        checkOutput("sticky_set_wins", 32'(led), 32'h01);

        // Clear the flag page back to zero, then auto scan from page 7
        applyStimulus(1'b0, DIN_A, 2'b00, 4'd7, 1'b0, 1'b0, 1'b1);
        waitCycles(1);
        checkOutput("auto_start_page", 32'(page), 32'd7);
        applyStimulus(1'b0, DIN_A, 2'b00, 4'd7, 1'b1, 1'b0, 1'b0);
        waitCycles(3);
        checkOutput("auto_dwell_page", 32'(page), 32'd7);
        checkOutput("auto_dwell_tick", 32'(page_tick), 32'd0);
        waitCycles(1);
        checkOutput("auto_adv_page", 32'(page), 32'd8);
        checkOutput("auto_adv_tick", 32'(page_tick), 32'd1);
        waitCycles(3);
        checkOutput("auto_dwell2_page", 32'(page), 32'd8);
        waitCycles(1);
        checkOutput("auto_wrap_page", 32'(page), 32'd0);
        checkOutput("auto_wrap_tick", 32'(page_tick), 32'd1);
        checkOutput("auto_wrap_led", 32'(led), 32'h44);
        tickCount = 0;
        for (int i = 0; i < 36; i++) begin
            waitCycles(1);
            if (page_tick === 1'b1) tickCount++;
        end
        checkOutput("ticks_per_36", 32'(tickCount), 32'd9);

        // Freeze with dwell counter at 2
        waitCycles(2);
        p0 = page;
        l0 = led;
        checkOutput("freeze_start_page", 32'(p0), 32'd0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, {$urandom, $urandom}, 2'b00, 4'($urandom), 1'b1, 1'b1, 1'b0);
            waitCycles(1);
            checkOutput("freeze_page", 32'(page), 32'(p0));
            checkOutput("freeze_led", 32'(led), 32'(l0));
            checkOutput("freeze_tick", 32'(page_tick), 32'd0);
        end
        applyStimulus(1'b0, DIN_A, 2'b00, 4'd0, 1'b1, 1'b0, 1'b0);
        waitCycles(1);
        checkOutput("release_hold_tick", 32'(page_tick), 32'd0);
        waitCycles(1);
        checkOutput("release_adv_page", 32'(page), 32'd1);
        checkOutput("release_adv_tick", 32'(page_tick), 32'd1);

        // Reset mid-scan at page 5, counter 3
        applyStimulus(1'b0, DIN_A, 2'b00, 4'd5, 1'b0, 1'b0, 1'b0);
        waitCycles(1);
        applyStimulus(1'b0, DIN_A, 2'b00, 4'd5, 1'b1, 1'b0, 1'b0);
        waitCycles(3);
        checkOutput("midscan_page", 32'(page), 32'd5);
        applyStimulus(1'b1, DIN_A, 2'b11, 4'd5, 1'b1, 1'b0, 1'b0);
        waitCycles(1);
        checkOutput("midscan_rst_page", 32'(page), 32'd0);
        checkOutput("midscan_rst_led", 32'(led), 32'h0);
        checkOutput("midscan_rst_tick", 32'(page_tick), 32'd0);
        applyStimulus(1'b0, DIN_A, 2'b00, 4'd5, 1'b1, 1'b0, 1'b0);
        waitCycles(3);
        checkOutput("post_rst_dwell_page", 32'(page), 32'd0);
        waitCycles(1);
        checkOutput("post_rst_adv_page", 32'(page), 32'd1);
        checkOutput("post_rst_adv_tick", 32'(page_tick), 32'd1);

        // Random traffic, checked by the model every cycle
        curAuto = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) curAuto = ~curAuto;
            applyStimulus($urandom_range(0, 149) == 0, {$urandom, $urandom}, 2'($urandom_range(0, 7) == 0 ? $urandom : 0),
                          4'($urandom), curAuto, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
            waitCycles(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
